fifo_write_gray_ctrl: RTL and testbench

FIFO_WRITE_GRAY_CTRL -- requirements
Module: fifo_write_gray_ctrl

---
 rtl/fifo_write_gray_ctrl.sv | 104 ++++++++++
 tb/tb_fifo_write_gray_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_gray_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_write_gray_ctrl
// Write-side controller of an asynchronous FIFO. Keeps a binary head pointer,
// publishes its Gray-coded copy for the read-domain synchronizer, brings the
// read Gray pointer into wr_clk through two flops, and derives a conservative
// full flag, fill level, almost-full flag and sticky overflow indication.
//
// Ports
//   wr_clk         in   1    write-domain clock
//   wr_rst         in   1    synchronous active-high reset
//   wr_en          out  1    BRAM write enable, high on accepted beats
//   i_valid        in   1    upstream beat valid
//   o_ready        out  1    beat can be accepted this cycle
//   i_rd_grayptr   in   N+1  read-side Gray pointer (async to wr_clk)
//   o_wr_intptr    out  N    BRAM write address of the current beat
//   o_wr_grayptr   out  N+1  registered write Gray pointer
//   o_fill_level   out  N+1  conservative occupancy 0..2**N
//   o_almost_full  out  1    o_fill_level >= INT_ALMOST_FULL_THRESH
//   o_overflow     out  1    sticky: beat offered while full
//   i_clear_ovf    in   1    clears o_overflow (a new overflow wins)
// ----------------------------------------------------------------------------
module fifo_write_gray_ctrl #(
    parameter int INT_FIFO_PTR_BITS_CNT  = 9,
    parameter int INT_ALMOST_FULL_THRESH = 2**INT_FIFO_PTR_BITS_CNT - 4
) (
    input  logic                             wr_clk,
    input  logic                             wr_rst,
    output logic                             wr_en,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [INT_FIFO_PTR_BITS_CNT:0]   i_rd_grayptr,
    output logic [INT_FIFO_PTR_BITS_CNT-1:0] o_wr_intptr,
    output logic [INT_FIFO_PTR_BITS_CNT:0]   o_wr_grayptr,
    output logic [INT_FIFO_PTR_BITS_CNT:0]   o_fill_level,
    output logic                             o_almost_full,
    output logic                             o_overflow,
    input  logic                             i_clear_ovf
);

    localparam int N = INT_FIFO_PTR_BITS_CNT;

    // Full when the write Gray pointer equals the read Gray pointer with its
    // two MSBs inverted; for N=1 this mask covers both bits.
    localparam logic [N:0] FULL_MASK = (N+1)'(3) << (N-1);
    localparam logic [N:0] AF_THRESH = (N+1)'(INT_ALMOST_FULL_THRESH);

    logic [N:0] head_ptr;
    logic [N:0] head_next;
    logic [N:0] gray_next;
    logic [N:0] rd_sync1;
    logic [N:0] rd_sync2;
    logic [N:0] rd_bin;
    logic [N:0] fill_next;
    logic       full;
    logic       rst_hold;
    logic       accept;

    always_comb begin
        // Reset is also gated in directly so no beat is accepted on the edge
        // that reset is sampled.
        o_ready     = ~full & ~rst_hold & ~wr_rst;
        accept      = i_valid & o_ready;
        wr_en       = accept;
        o_wr_intptr = head_ptr[N-1:0];
        head_next   = head_ptr + (N+1)'(accept);
        gray_next   = head_next ^ (head_next >> 1);

        rd_bin = '0;
        for (int unsigned k = 0; k <= N; k++) begin
            rd_bin[k] = ^(rd_sync2 >> k);
        end

        fill_next = head_next - rd_bin;
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            head_ptr      <= '0;
            o_wr_grayptr  <= '0;
            rd_sync1      <= '0;
            rd_sync2      <= '0;
            full          <= 1'b0;
            o_fill_level  <= '0;
            o_almost_full <= 1'b0;
            o_overflow    <= 1'b0;
            rst_hold      <= 1'b1;
        end else begin
            head_ptr      <= head_next;
            o_wr_grayptr  <= gray_next;
            rd_sync1      <= i_rd_grayptr;
            rd_sync2      <= rd_sync1;
            full          <= (gray_next == (rd_sync2 ^ FULL_MASK));
            o_fill_level  <= fill_next;
            o_almost_full <= (fill_next >= AF_THRESH);
            rst_hold      <= 1'b0;
            if (i_valid & full) begin
                o_overflow <= 1'b1;
            end else if (i_clear_ovf) begin
                o_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_write_gray_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fifo_write_gray_ctrl
// Directed and randomized bench for fifo_write_gray_ctrl with depth 8,
// almost-full threshold 6. The reference tracks written and read beat counts
// as plain integers; the read pointer is only seen two wr_clk edges late.
// ----------------------------------------------------------------------------
module tb_fifo_write_gray_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic       valid;
    logic       ready;
    logic [3:0] rd_gray;
    logic [2:0] wr_intptr;
    logic [3:0] wr_gray;
    logic [3:0] fill;
    logic       afull;
    logic       ovf;
    logic       clr;

    fifo_write_gray_ctrl #(
        .INT_FIFO_PTR_BITS_CNT (3),
        .INT_ALMOST_FULL_THRESH(6)
    ) dut (
        .wr_clk       (clk),
        .wr_rst       (rst),
        .wr_en        (wr_en),
        .i_valid      (valid),
        .o_ready      (ready),
        .i_rd_grayptr (rd_gray),
        .o_wr_intptr  (wr_intptr),
        .o_wr_grayptr (wr_gray),
        .o_fill_level (fill),
        .o_almost_full(afull),
        .o_overflow   (ovf),
        .i_clear_ovf  (clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: beats written, beats read, and what the write side
    // has seen of the read count (one and two edges old).
    int   m_w    = 0;
    int   rd_drv = 0;
    int   s1     = 0;
    int   s2     = 0;
    logic m_full = 1'b0;
    int   m_fill = 0;
    logic m_af   = 1'b0;
    logic m_ovf  = 1'b0;
    logic m_hold = 1'b1;
    int   acc_cnt = 0;

    int gtab[9] = '{0, 1, 3, 2, 6, 7, 5, 4, 12};

    function automatic logic [3:0] g4(input int b);
        logic [3:0] x;
        x = b[3:0];
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic c, input logic r);
        logic rdy_m;
        logic acc;
        logic old_full;
        int   wn;
        int   occ;
        valid   = v;
        clr     = c;
        rst     = r;
        rd_gray = g4(rd_drv);
        #1;
        rdy_m = !m_full && !m_hold && !r;
        acc   = v && rdy_m;
        chk("ready_pre", 32'(ready), 32'(rdy_m));
        chk("wr_en", 32'(wr_en), 32'(acc));
        if (!r) chk("wr_addr", 32'(wr_intptr), 32'(m_w & 7));
        @(posedge clk);
        if (r) begin
            m_w = 0; m_full = 0; m_fill = 0; m_af = 0; m_ovf = 0;
            m_hold = 1; s1 = 0; s2 = 0;
        end else begin
            old_full = m_full;
            wn       = m_w + int'(acc);
            occ      = (wn - s2) & 15;
            m_ovf    = (v && old_full) ? 1'b1 : (c ? 1'b0 : m_ovf);
            m_full   = (occ == 8);
            m_fill   = occ;
            m_af     = (occ >= 6);
            m_w      = wn;
            m_hold   = 0;
            s2       = s1;
            s1       = rd_drv;
            if (acc) acc_cnt++;
        end
        #1;
        chk("gray", 32'(wr_gray), 32'(g4(m_w)));
        chk("fill", 32'(fill), 32'(m_fill));
        chk("almost_full", 32'(afull), 32'(m_af));
        chk("overflow", 32'(ovf), 32'(m_ovf));
        chk("ready_post", 32'(ready), 32'(!m_full && !m_hold && !r));
        chk("no_overrun", 32'((m_w - rd_drv) <= 8), 32'(1));
    endtask

    task automatic do_reset();
        rd_drv = 0;
        repeat (3) step(1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        logic [3:0] prev_gray;
        int         n;
        valid = 0; clr = 0; rst = 1; rd_gray = '0;

        // Reset with valid held high; ready must stay low one cycle after release.
        do_reset();
        chk("rst_gray", 32'(wr_gray), 32'(0));
        chk("rst_fill", 32'(fill), 32'(0));
        step(1'b1, 1'b0, 1'b0);

        // Fill to full with the read pointer parked at 0.
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (m_w <= 8) chk("gray_seq", 32'(wr_gray), 32'(gtab[m_w]));
        end
        chk("full_fill", 32'(fill), 32'(8));
        chk("full_ready", 32'(ready), 32'(0));
        chk("full_af", 32'(afull), 32'(1));

        // Overflow: offers while full, set beats clear, then a clean clear.
        repeat (3) step(1'b1, 1'b0, 1'b0);
        chk("ovf_set", 32'(ovf), 32'(1));
        chk("ovf_head_held", 32'(wr_intptr), 32'(0));
        step(1'b1, 1'b1, 1'b0);
        chk("ovf_set_wins", 32'(ovf), 32'(1));
        step(1'b0, 1'b1, 1'b0);
        chk("ovf_cleared", 32'(ovf), 32'(0));

        // One read frees one slot; ready returns within three cycles.
        rd_drv = 1;
        n = 0;
        while (!ready && n < 4) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("ready_after_read", 32'(ready), 32'(1));
        chk("ready_latency_ok", 32'(n <= 3), 32'(1));
        valid = 1'b1;
        #1;
        chk("refill_addr", 32'(wr_intptr), 32'(0));
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("full_again", 32'(ready), 32'(0));

        // Random traffic with a read side that never overtakes the writes.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1 && rd_drv < m_w) rd_drv++;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'b0);
        end

        // Streaming with the reader two beats behind: wraps, never full.
        do_reset();
        step(1'b0, 1'b0, 1'b0);
        acc_cnt   = 0;
        prev_gray = wr_gray;
        n = 0;
        while (acc_cnt < 40 && n < 100) begin
            if (m_w - rd_drv > 2) rd_drv++;
            step(1'b1, 1'b0, 1'b0);
            chk("gray_1bit", 32'($countones(wr_gray ^ prev_gray) <= 1), 32'(1));
            chk("stream_ready", 32'(ready), 32'(1));
            prev_gray = wr_gray;
            n++;
        end
        chk("stream_beats", 32'(acc_cnt), 32'(40));
        chk("stream_no_ovf", 32'(ovf), 32'(0));

        // Reset in the middle of a burst at head 5.
        do_reset();
        step(1'b0, 1'b0, 1'b0);
        rd_drv = 0;
        n = 0;
        while (m_w < 5 && n < 20) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        chk("burst_head5", 32'(wr_intptr), 32'(5));
        step(1'b1, 1'b0, 1'b1);
        chk("midrst_addr", 32'(wr_intptr), 32'(0));
        chk("midrst_gray", 32'(wr_gray), 32'(0));
        chk("midrst_fill", 32'(fill), 32'(0));
        chk("midrst_ready", 32'(ready), 32'(0));
        step(1'b1, 1'b0, 1'b0);
        valid = 1'b1;
        #1;
        chk("first_after_rst_en", 32'(wr_en), 32'(1));
        chk("first_after_rst_addr", 32'(wr_intptr), 32'(0));
        step(1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
